// File: rtl/bus_ctrl_seq.sv
// Fetch/decode/execute sequencer driving the core's bus source/destination selects and memory strobes.
// Latency: Moore outputs from state and latched IR; NOP 2, MOVA/MOVF/STORE 3, LOAD 4 cycles. No backpressure.
module bus_ctrl_seq #(
   parameter int SRC_N = 12,
   parameter int DST_N = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      ir_in,
   output logic [SRC_N-1:0] read_en,
   output logic [DST_N-1:0] wr_en,
   output logic             pc_inc,
   output logic             dm_rd,
   output logic             dm_wr,
   output logic             busy,
   output logic             halted,
   output logic             illegal
);

   localparam int SRC_IM = 0;
   localparam int SRC_DR = 1;
   localparam int SRC_DM = 2;
   localparam int SRC_AC = 3;
   localparam int SRC_AR = 5;
   localparam int DST_IR = 0;
   localparam int DST_DR = 1;
   localparam int DST_AC = 3;

   localparam logic [4:0] SRC_LIM = 5'(SRC_N);
   localparam logic [4:0] DST_LIM = 5'(DST_N);

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_MOVA  = 4'h1;
   localparam logic [3:0] OP_MOVF  = 4'h2;
   localparam logic [3:0] OP_LOAD  = 4'h3;
   localparam logic [3:0] OP_STORE = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC1,
      S_EXEC2,
      S_HALTED
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] op_q, fld_q;
   logic       illegal_q;
   logic       dec_illegal;
   logic [3:0] in_op, in_fld;
   logic       ir_unused;

   assign in_op     = ir_in[15:12];
   assign in_fld    = ir_in[3:0];
   assign ir_unused = ^ir_in[11:4];

   always_comb begin
      dec_illegal = 1'b0;
      case (in_op)
         OP_NOP, OP_LOAD, OP_STORE, OP_HALT: dec_illegal = 1'b0;
         OP_MOVA: dec_illegal = ({1'b0, in_fld} >= SRC_LIM);
         // IR cannot be a MOVF destination.
         OP_MOVF: dec_illegal = (in_fld == 4'd0) || ({1'b0, in_fld} >= DST_LIM);
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            if (dec_illegal)           state_nxt = S_HALTED;
            else if (in_op == OP_NOP)  state_nxt = S_FETCH;
            else if (in_op == OP_HALT) state_nxt = S_HALTED;
            else                       state_nxt = S_EXEC1;
         end
         S_EXEC1:  state_nxt = (op_q == OP_LOAD) ? S_EXEC2 : S_FETCH;
         S_EXEC2:  state_nxt = S_FETCH;
         S_HALTED: state_nxt = S_HALTED;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= 4'd0;
         fld_q     <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            op_q  <= in_op;
            fld_q <= in_fld;
            if (dec_illegal) illegal_q <= 1'b1;
         end
      end
   end

   always_comb begin
      read_en = '0;
      wr_en   = '0;
      pc_inc  = 1'b0;
      dm_rd   = 1'b0;
      dm_wr   = 1'b0;
      case (state)
         S_FETCH: begin
            read_en[SRC_IM] = 1'b1;
            wr_en[DST_IR]   = 1'b1;
            pc_inc          = 1'b1;
         end
         S_EXEC1: begin
            case (op_q)
               OP_MOVA: begin
                  read_en       = SRC_N'(1) << fld_q;
                  wr_en[DST_AC] = 1'b1;
               end
               OP_MOVF: begin
                  read_en[SRC_AC] = 1'b1;
                  wr_en           = DST_N'(1) << fld_q;
               end
               // LOAD first phase: AR on the bus is the memory address.
               OP_LOAD: begin
                  read_en[SRC_AR] = 1'b1;
                  dm_rd           = 1'b1;
               end
               OP_STORE: begin
                  read_en[SRC_DR] = 1'b1;
                  dm_wr           = 1'b1;
               end
               default: ;
            endcase
         end
         S_EXEC2: begin
            read_en[SRC_DM] = 1'b1;
            wr_en[DST_DR]   = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy    = (state != S_IDLE) && (state != S_HALTED);
   assign halted  = (state == S_HALTED);
   assign illegal = illegal_q;

   a_read_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(read_en));

endmodule

// File: tb/tb_bus_ctrl_seq.sv
// Scoreboarded bench for bus_ctrl_seq: stimulus queues expected per-cycle outputs, a negedge monitor compares.
module tb_bus_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] ir_in = 16'h0000;
   logic [11:0] read_en;
   logic [9:0]  wr_en;
   logic        pc_inc, dm_rd, dm_wr, busy, halted, illegal;

   bus_ctrl_seq #(.SRC_N(12), .DST_N(10)) dut (
      .clk(clk), .rst(rst), .start(start), .ir_in(ir_in),
      .read_en(read_en), .wr_en(wr_en), .pc_inc(pc_inc),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .busy(busy),
      .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Field order: read_en, wr_en, pc_inc, dm_rd, dm_wr, busy, halted, illegal.
   typedef struct packed {
      logic [11:0] rd;
      logic [9:0]  wr;
      logic        pc;
      logic        dr;
      logic        dw;
      logic        bsy;
      logic        hlt;
      logic        ill;
   } exp_t;

   localparam exp_t E_ZERO   = {12'h000, 10'h000, 6'b000000};
   localparam exp_t E_FETCH  = {12'h001, 10'h001, 6'b100100};
   localparam exp_t E_DECODE = {12'h000, 10'h000, 6'b000100};
   localparam exp_t E_HALT   = {12'h000, 10'h000, 6'b000010};
   localparam exp_t E_ILL    = {12'h000, 10'h000, 6'b000011};

   exp_t exp_q[$];
   int   tag_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tnum  = 0;
   exp_t act;

   assign act = {read_en, wr_en, pc_inc, dm_rd, dm_wr, busy, halted, illegal};

   always @(negedge clk) begin
      exp_t e;
      int   t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_cmp++;
         if (act !== e) begin
            n_bad++;
            $display("FAIL t%0d_outputs got rd=%03h wr=%03h pc/dmr/dmw/busy/halt/ill=%06b required rd=%03h wr=%03h pc/dmr/dmw/busy/halt/ill=%06b",
                     t, act.rd, act.wr, act[5:0], e.rd, e.wr, e[5:0]);
         end
         n_cmp++;
         if (!$onehot0(read_en)) begin
            n_bad++;
            $display("FAIL t%0d_onehot read_en=%03h required at most one bit set", t, read_en);
         end
      end
   end

   function automatic exp_t mk(input logic [11:0] rd, input logic [9:0] wr,
                               input logic dr, input logic dw);
      mk = {rd, wr, 1'b0, dr, dw, 1'b1, 1'b0, 1'b0};
   endfunction

   task automatic cyc(input exp_t e);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      tag_q.push_back(tnum);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      cyc(E_ZERO);
      cyc(E_ZERO);
      rst = 1'b0;
   endtask

   // FETCH and DECODE with junk on ir_in, then present ir for the DECODE exit edge.
   task automatic fd(input logic [15:0] ir);
      cyc(E_FETCH);
      ir_in = 16'($urandom);
      cyc(E_DECODE);
      ir_in = ir;
   endtask

   logic [15:0] ill_tab [5] = '{16'h100C, 16'h7000, 16'h2000, 16'h200A, 16'hE123};

   initial begin
      logic [3:0]  op, fld;
      logic [7:0]  mid;
      logic [11:0] one12;
      logic [9:0]  one10;

      // 1: MOVA B, then NOP, and back to FETCH
      tnum = 1;
      do_reset();
      start = 1'b1;
      fd(16'h1007);
      cyc(mk(12'h080, 10'h008, 1'b0, 1'b0));
      fd(16'h0000);

      // 2: LOAD
      tnum = 2;
      fd(16'h3000);
      cyc(mk(12'h020, 10'h000, 1'b1, 1'b0));
      cyc(mk(12'h004, 10'h002, 1'b0, 1'b0));

      // 3: MOVF D, STORE, MOVA AC, HALT; start is ignored in HALTED
      tnum = 3;
      fd(16'h2008);
      cyc(mk(12'h008, 10'h100, 1'b0, 1'b0));
      fd(16'h4000);
      cyc(mk(12'h002, 10'h000, 1'b0, 1'b1));
      fd(16'h1003);
      cyc(mk(12'h008, 10'h008, 1'b0, 1'b0));
      fd(16'hF000);
      cyc(E_HALT);
      repeat (3) cyc(E_HALT);

      // 4: illegal encodings halt with sticky illegal
      tnum = 4;
      foreach (ill_tab[i]) begin
         do_reset();
         start = 1'b1;
         fd(ill_tab[i]);
         cyc(E_ILL);
         repeat (3) cyc(E_ILL);
      end

      // 5: reset during LOAD EXEC1
      tnum = 5;
      do_reset();
      start = 1'b1;
      fd(16'h3000);
      cyc(mk(12'h020, 10'h000, 1'b1, 1'b0));
      rst = 1'b1;
      cyc(E_ZERO);
      rst   = 1'b0;
      start = 1'b0;
      cyc(E_ZERO);
      cyc(E_ZERO);

      // 6: random legal instruction stream
      tnum = 6;
      start = 1'b1;
      one12 = 12'h001;
      one10 = 10'h001;
      for (int n = 0; n < 3000; n++) begin
         op  = 4'($urandom_range(0, 4));
         mid = 8'($urandom);
         case (op)
            4'h1:    fld = 4'($urandom_range(0, 11));
            4'h2:    fld = 4'($urandom_range(1, 9));
            default: fld = 4'($urandom);
         endcase
         fd({op, mid, fld});
         case (op)
            4'h1: cyc(mk(one12 << fld, 10'h008, 1'b0, 1'b0));
            4'h2: cyc(mk(12'h008, one10 << fld, 1'b0, 1'b0));
            4'h3: begin
               cyc(mk(12'h020, 10'h000, 1'b1, 1'b0));
               cyc(mk(12'h004, 10'h002, 1'b0, 1'b0));
            end
            4'h4: cyc(mk(12'h002, 10'h000, 1'b0, 1'b1));
            default: ;
         endcase
      end
      fd(16'hF000);
      cyc(E_HALT);

      tnum = 7;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
